uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver: recovers DATA_WIDTH-bit words from the serial 'rx' line using the
//  shared 16x-oversampled sample_tick from the baud generator. Mirror of the UART
//  transmitter: LSB first, 1 start bit, optional parity, STOP_BITS stop bits.
//  Sits between the board RX pin and the RX FIFO/host logic; flags parity and framing errors.
// PARAMETERS
//  DATA_WIDTH  8  data bits per word (5..8)
//  STOP_BITS   1  stop bits expected per frame (1..2)
// PORTS
//  clk          in   1           system clock
//  rst          in   1           reset, synchronous, active-high
//  rx           in   1           serial input, idle high
//  sample_tick  in   1           one-clk strobe at 16x baud
//  parity_mode  in   2           00 none, 01 even, 10 odd, 11 treated as none
//  dout         out  DATA_WIDTH  received word, valid when rx_done=1, held until next rx_done
//  rx_done      out  1           one-clk pulse: frame complete
//  parity_err   out  1           parity mismatch for frame in dout (0 if parity off)
//  frame_err    out  1           any stop bit sampled low for frame in dout
//  rx_busy      out  1           1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, counters 0, dout=0, rx_done=0, parity_err=0, frame_err=0.
//    rst mid-frame discards the partial word; no rx_done.
//  - All state/counter updates only on clk edges where sample_tick=1 (except rx_done clear).
//  - rx_s = rx (or synchronised rx, see CONFIGURATION); sample counter 4 bit, wraps 15->0.
//  - IDLE: on tick with rx_s=0 -> START, count=0. parity_mode latched here (per frame).
//  - START: count to 7 (mid-bit). At count 7: rx_s=0 -> DATA, count=0, index=0;
//    rx_s=1 -> false start, back to IDLE, no outputs change.
//  - DATA: at count 15 sample rx_s into shift reg MSB, shift right (LSB first); count=0.
//    After bit DATA_WIDTH-1: -> PARITY if latched mode is 01/10, else STOP.
//  - PARITY: at count 15 sample bit p. Error if even: p != ^data; odd: p != ~^data.
//  - STOP: at count 15 sample; rx_s=0 sets frame flag. After STOP_BITS stop bits:
//    -> IDLE, next clk dout<=word, parity_err/frame_err<=flags, rx_done=1 for exactly 1 clk.
//    Flags cleared at START entry.
//  - Mid-bit sampling: every post-start sample is 16 ticks apart at start-bit centre +16n.
//  - Break (rx held low): frame_err=1, rx_done pulses, then IDLE immediately sees rx=0
//    and starts a new frame; no lock-up.
//  - Back-to-back frames: new start bit accepted on the first tick after returning to IDLE.
//  - sample_tick held high continuously is legal (tick every clk).
//  - Unused state encodings -> IDLE.
// CONFIGURATION
//  UART_RX_SYNC_EN defined: rx passes through 2-flop synchroniser (both flops reset to 1)
//   before FSM; adds 2 clk latency to edge detection; required for the asynchronous pin.
//  Not defined: rx_s = rx directly; caller guarantees rx is synchronous to clk.
// TESTING (bench: sample_tick every 4 clks, DATA_WIDTH=8, STOP_BITS=1 unless stated)
//  1. parity 00, send 0xA5 (64 clks/bit) -> one rx_done pulse, dout=0xA5, both errs 0.
//  2. parity 01, send 0x07 with parity bit 1 -> dout=0x07, parity_err=0; same with
//     parity bit 0 -> parity_err=1. Repeat odd (10): 0x07 needs parity 0.
//  3. rx low for 4 ticks then high -> false start, rx_busy returns 0, no rx_done.
//  4. send 0x3C with stop bit 0 -> rx_done, dout=0x3C, frame_err=1; then 0x55 back-to-back
//     with valid stop -> dout=0x55, frame_err=0.
//  5. STOP_BITS=2, frames 0x00 and 0xFF back-to-back -> two rx_done pulses, correct data.
//  6. assert rst during bit 4 of a frame -> outputs at reset values, no rx_done; next
//     clean frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (LSB first, optional even/odd parity, STOP_BITS stops).
// Define UART_RX_SYNC_EN to route rx through a 2-flop synchroniser before the FSM.
module uart_rx #(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   input  logic                  sample_tick,
   input  logic [1:0]            parity_mode,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  rx_done,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  rx_busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic [3:0] MID_CNT   = 4'd7;
   localparam logic [3:0] LAST_CNT  = 4'd15;
   localparam logic [2:0] LAST_IDX  = 3'(DATA_WIDTH - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   // Parity bit p is wrong for word under the given mode; 00/11 never flag.
   function automatic logic parity_bad(input logic [1:0] mode,
                                       input logic [DATA_WIDTH-1:0] word,
                                       input logic p);
      logic bad;
      case (mode)
         2'b01:   bad = (p != ^word);
         2'b10:   bad = (p != ~^word);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

   logic rx_s;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync_q;

   // Two-flop synchroniser for the asynchronous pin, idle-high out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx};
      end
   end

   assign rx_s = sync_q[1];
`else
   assign rx_s = rx;
`endif

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [2:0]            idx_q, idx_d;
   logic                  stop_q, stop_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [1:0]            mode_q, mode_d;
   logic                  pflag_q, pflag_d;
   logic                  fflag_q, fflag_d;
   logic                  done_d;

   logic [DATA_WIDTH-1:0] dout_q;
   logic                  done_q;
   logic                  perr_q;
   logic                  ferr_q;

   // FSM and datapath state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= 3'd0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         mode_q  <= 2'b00;
         pflag_q <= 1'b0;
         fflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         mode_q  <= mode_d;
         pflag_q <= pflag_d;
         fflag_q <= fflag_d;
      end
   end

   // Next-state logic; everything advances only on sample_tick.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      mode_d  = mode_q;
      pflag_d = pflag_q;
      fflag_d = fflag_q;
      done_d  = 1'b0;

      if (sample_tick) begin
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_d = START;
                  cnt_d   = 4'd0;
                  mode_d  = parity_mode;
                  pflag_d = 1'b0;
                  fflag_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
            START: begin
               if (cnt_q == MID_CNT) begin
                  cnt_d = 4'd0;
                  idx_d = 3'd0;
                  // A high line at the start-bit centre is a glitch, not a frame.
                  if (!rx_s) begin
                     state_d = DATA;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            DATA: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = 4'd0;
                  shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                  if (idx_q == LAST_IDX) begin
                     idx_d  = 3'd0;
                     stop_d = 1'b0;
                     if ((mode_q == 2'b01) || (mode_q == 2'b10)) begin
                        state_d = PARITY;
                     end else begin
                        state_d = STOP;
                     end
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            PARITY: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = 4'd0;
                  stop_d  = 1'b0;
                  pflag_d = parity_bad(mode_q, shift_q, rx_s);
                  state_d = STOP;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            STOP: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_d = 4'd0;
                  if (!rx_s) begin
                     fflag_d = 1'b1;
                  end else begin
                     fflag_d = fflag_q;
                  end
                  if (stop_q == LAST_STOP) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     stop_d = stop_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end
         endcase
      end else begin
         done_d = 1'b0;
      end
   end

   // Output registers: word and flags are published together with the rx_done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q <= '0;
         done_q <= 1'b0;
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         done_q <= done_d;
         if (done_d) begin
            dout_q <= shift_q;
            perr_q <= pflag_q;
            ferr_q <= fflag_d;
         end
      end
   end

   assign dout       = dout_q;
   assign rx_done    = done_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a frame-level model.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_tick;
   logic [1:0] parity_mode;
   logic       rx_a, rx_b;
   logic [7:0] dout_a, dout_b;
   logic       done_a, done_b, perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;

   int errors = 0;
   int checks = 0;
   int tick_div = 0;

   // {data, parity_err, frame_err} per frame
   logic [9:0] got_a[$], got_b[$], exp_a[$], exp_b[$];

   always #5 clk = ~clk;

   uart_rx #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst(rst), .rx(rx_a), .sample_tick(sample_tick), .parity_mode(parity_mode),
      .dout(dout_a), .rx_done(done_a), .parity_err(perr_a), .frame_err(ferr_a), .rx_busy(busy_a)
   );

   uart_rx #(.DATA_WIDTH(8), .STOP_BITS(2)) dut_b (
      .clk(clk), .rst(rst), .rx(rx_b), .sample_tick(sample_tick), .parity_mode(parity_mode),
      .dout(dout_b), .rx_done(done_b), .parity_err(perr_b), .frame_err(ferr_b), .rx_busy(busy_b)
   );

   initial begin
      sample_tick = 1'b0;
      forever begin
         @(negedge clk);
         tick_div = (tick_div + 1) % 4;
         sample_tick = (tick_div == 0);
      end
   end

   always @(negedge clk) begin
      if (done_a === 1'b1) got_a.push_back({dout_a, perr_a, ferr_a});
      if (done_b === 1'b1) got_b.push_back({dout_b, perr_b, ferr_b});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_perr(input logic [1:0] mode, input logic [7:0] d, input logic p);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      if (mode == 2'b01) return p != (ones % 2 == 1);
      if (mode == 2'b10) return p != (ones % 2 == 0);
      return 1'b0;
   endfunction

   task automatic send_bit(input bit which, input logic v);
      if (which) rx_b = v; else rx_a = v;
      repeat (64) @(negedge clk);
   endtask

   task automatic send_frame(input bit which, input logic [7:0] d, input logic [1:0] mode,
                             input logic p, input int nstop, input logic stopval);
      parity_mode = mode;
      send_bit(which, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(which, d[i]);
      if (mode == 2'b01 || mode == 2'b10) send_bit(which, p);
      for (int s = 0; s < nstop; s++) send_bit(which, stopval);
      if (which) exp_b.push_back({d, model_perr(mode, d, p), ~stopval});
      else       exp_a.push_back({d, model_perr(mode, d, p), ~stopval});
   endtask

   task automatic check_frames(input bit which, input string tag);
      int guard = 0;
      logic [9:0] e, g;
      while (((which ? got_b.size() : got_a.size()) < (which ? exp_b.size() : exp_a.size()))
             && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "_count"}, which ? got_b.size() : got_a.size(),
            which ? exp_b.size() : exp_a.size());
      while ((which ? exp_b.size() : exp_a.size()) > 0) begin
         e = which ? exp_b.pop_front() : exp_a.pop_front();
         if ((which ? got_b.size() : got_a.size()) > 0) begin
            g = which ? got_b.pop_front() : got_a.pop_front();
            check({tag, "_dout"},  32'(g[9:2]), 32'(e[9:2]));
            check({tag, "_perr"},  32'(g[1]),   32'(e[1]));
            check({tag, "_ferr"},  32'(g[0]),   32'(e[0]));
         end
      end
      got_a.delete();
      got_b.delete();
   endtask

   initial begin
      logic [7:0] rd;
      logic [1:0] rm;
      logic       rp, rs;

      rst = 1'b1;
      rx_a = 1'b1;
      rx_b = 1'b1;
      parity_mode = 2'b00;
      repeat (4) @(negedge clk);
      check("reset_dout", 32'(dout_a), 32'h0);
      check("reset_done", 32'(done_a), 32'h0);
      check("reset_busy", 32'(busy_a), 32'h0);
      check("reset_errs", 32'({perr_a, ferr_a}), 32'h0);
      rst = 1'b0;
      repeat (16) @(negedge clk);

      // 1: plain frame
      send_frame(1'b0, 8'hA5, 2'b00, 1'b0, 1, 1'b1);
      check_frames(1'b0, "t1");

      // 2: even then odd parity, good and bad parity bits
      send_frame(1'b0, 8'h07, 2'b01, 1'b1, 1, 1'b1);
      send_frame(1'b0, 8'h07, 2'b01, 1'b0, 1, 1'b1);
      send_frame(1'b0, 8'h07, 2'b10, 1'b0, 1, 1'b1);
      send_frame(1'b0, 8'h07, 2'b10, 1'b1, 1, 1'b1);
      check_frames(1'b0, "t2");

      // 3: false start
      rx_a = 1'b0;
      repeat (8) @(negedge clk);
      check("t3_busy_hi", 32'(busy_a), 32'h1);
      repeat (8) @(negedge clk);
      rx_a = 1'b1;
      repeat (80) @(negedge clk);
      check("t3_busy_lo", 32'(busy_a), 32'h0);
      check("t3_no_done", 32'(got_a.size()), 32'h0);

      // 4: bad stop then good frame (one idle bit absorbs the low-stop restart)
      send_frame(1'b0, 8'h3C, 2'b00, 1'b0, 1, 1'b0);
      send_bit(1'b0, 1'b1);
      send_frame(1'b0, 8'h55, 2'b00, 1'b0, 1, 1'b1);
      check_frames(1'b0, "t4");

      // 5: two stop bits, back-to-back
      send_frame(1'b1, 8'h00, 2'b00, 1'b0, 2, 1'b1);
      send_frame(1'b1, 8'hFF, 2'b00, 1'b0, 2, 1'b1);
      check_frames(1'b1, "t5");

      // 6: reset during data bit 4, then a clean frame
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
      rx_a = 1'b0;
      repeat (32) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("t6_rst_dout", 32'(dout_a), 32'h0);
      check("t6_rst_busy", 32'(busy_a), 32'h0);
      check("t6_rst_errs", 32'({perr_a, ferr_a, done_a}), 32'h0);
      rx_a = 1'b1;
      rst = 1'b0;
      repeat (128) @(negedge clk);
      check("t6_no_done", 32'(got_a.size()), 32'h0);
      check("t6_idle", 32'(busy_a), 32'h0);
      send_frame(1'b0, 8'h81, 2'b00, 1'b0, 1, 1'b1);
      check_frames(1'b0, "t6");

      // random frames against the model
      for (int n = 0; n < 10; n++) begin
         rd = 8'($urandom_range(0, 255));
         rm = 2'($urandom_range(0, 3));
         rp = 1'($urandom_range(0, 1));
         rs = ($urandom_range(0, 3) != 0);
         send_frame(1'b0, rd, rm, rp, 1, rs);
         if (!rs) send_bit(1'b0, 1'b1);
      end
      check_frames(1'b0, "rand");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
